deser160_daq_arbiter: RTL

Merges the 16-bit word streams of NCH deser160 serial-to-parallel channels onto one DAQ output port.
- Each channel's one-clock write strobes feed a per-channel FIFO.
- A round-robin scheduler drains the FIFOs into a single registered output with valid/ready handshake, tagging each word with its channel number.
- Sits between the serpar instances and the DAQ memory writer.
- Provides per-channel enable gating, flush and sticky overflow flags.

---
 rtl/deser160_daq_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/deser160_daq_arbiter.sv
// Merges NCH deser160 word streams onto one DAQ port: per-channel FIFOs drained
// round-robin into a registered valid/ready output tagged with the source channel.
module deser160_daq_arbiter #(
  parameter int NCH   = 4,
  parameter int CW    = 2,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      enable,
  input  logic                clear,
  input  logic [NCH-1:0]      in_write,
  input  logic [16*NCH-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_data,
  output logic [CW-1:0]       out_chan,
  output logic [NCH-1:0]      overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CW-1:0]   LAST_CH  = CW'(NCH - 1);

  logic [15:0]                mem [NCH][DEPTH];
  logic [NCH-1:0][AW-1:0]     rd_ptr;
  logic [NCH-1:0][AW-1:0]     wr_ptr;
  logic [NCH-1:0][CNTW-1:0]   count;
  logic [CW-1:0]              rr_ptr;

  logic [NCH-1:0]             not_empty;
  logic [NCH-1:0]             full;
  logic [NCH-1:0]             push;
  logic [NCH-1:0]             pop;
  logic [NCH-1:0]             drop;
  logic                       load;
  logic                       grant_found;
  logic [CW-1:0]              grant_idx;
  logic [15:0]                grant_data;

  // The output register may take a new word whenever it is empty or being accepted.
  assign load = !out_valid || out_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    not_empty = '0;
    full      = '0;
    for (int i = 0; i < NCH; i++) begin
      not_empty[i] = (count[i] != '0);
      full[i]      = (count[i] == FULL_CNT);
    end
  end

  // Search starts just after the last granted channel, so a channel that was
  // just served has lowest priority on the next grant.
  always_comb begin
    logic [CW-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    pop         = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CW'((int'(rr_ptr) + k) % NCH);
      if (!grant_found && not_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
        grant_data  = mem[cand][rd_ptr[cand]];
      end
    end
    if (load && grant_found) pop[grant_idx] = 1'b1;
  end

  // A full FIFO still accepts a word when its head leaves in the same cycle.
  always_comb begin
    push = '0;
    drop = '0;
    for (int i = 0; i < NCH; i++) begin
      push[i] = in_write[i] && enable[i] && (!full[i] || pop[i]);
      drop[i] = in_write[i] && enable[i] && full[i] && !pop[i];
    end
  end

  // NOTE: the storage array has no reset; emptiness is carried entirely by the
  // pointers and counts, so stale contents are never observable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[16*i +: 16];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNTW'(1);
          2'b01:   count[i] <= count[i] - CNTW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= LAST_CH;
      overflow  <= '0;
    end else begin
      overflow <= overflow | drop;
      if (load) begin
        if (grant_found) begin
          out_valid <= 1'b1;
          out_data  <= grant_data;
          out_chan  <= grant_idx;
          rr_ptr    <= grant_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
